// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Field positions describe the decoded instruction word layout.
package fetch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam int OP_LSB    = 26;
    localparam int FUNCT_LSB = 20;
    localparam int RD_LSB    = 12;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] sat_inc(
        input logic [31:0] v
    );
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding {instr, pc} between memory and decode.
// Flush empties it in one cycle; head is visible with no added latency.
module fetch_buffer #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] nxt(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order fetch with redirect flush.
// Define FETCH_STATS_EN to add saturating fetch/drop/stall counters.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = fetch_unit_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC =
        ADDR_W'(fetch_unit_pkg::RESET_PC),
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic [ADDR_W-1:0] dec_pc_plus8,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_dropped,
    output logic [31:0]       stat_stall
`endif
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] redirect_tgt;
    logic [CNT_W-1:0]  inflight;
    logic [CNT_W-1:0]  inflight_next;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    credit_sum;
    logic              req_fire;
    logic              rsp_drop;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_empty;
    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;
    logic [1:0]        unused_pc_lsb;

    assign unused_pc_lsb = redirect_pc[1:0];
    assign redirect_tgt  = {redirect_pc[ADDR_W-1:2], 2'b00};

    // Words in flight count against buffer space so a push never overflows.
    assign credit_sum = {1'b0, inflight} + {1'b0, buf_count};
    assign imem_req_valid =
        !reset && (credit_sum < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid &&
        (redirect_valid || state == DRAIN);
    assign buf_push = imem_rsp_valid && !rsp_drop;
    assign buf_pop  = dec_valid && dec_ready && !redirect_valid;

    always_comb begin
        inflight_next = inflight;
        case ({req_fire, imem_rsp_valid})
            2'b10:   inflight_next = inflight + CNT_W'(1);
            2'b01:   inflight_next = inflight - CNT_W'(1);
            default: inflight_next = inflight;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight_next;
            if (redirect_valid) begin
                fetch_pc <= redirect_tgt;
                resp_pc  <= redirect_tgt;
                drop_cnt <= inflight_next;
                state    <= (inflight_next != '0) ? DRAIN : FETCH;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (buf_push) begin
                    resp_pc <= resp_pc + ADDR_W'(4);
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CNT_W'(1);
                    if (drop_cnt == CNT_W'(1)) begin
                        state <= FETCH;
                    end
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (32 + ADDR_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (buf_push),
        .push_data ({imem_rsp_data, resp_pc}),
        .pop       (buf_pop),
        .head      ({head_instr, head_pc}),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign dec_valid    = !buf_empty;
    assign dec_instr    = dec_valid ? head_instr : '0;
    assign dec_pc       = dec_valid ? head_pc : '0;
    assign dec_pc_plus8 = dec_pc + ADDR_W'(8);

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
            stat_stall   <= '0;
        end else begin
            if (req_fire) begin
                stat_fetched <= sat_inc(stat_fetched);
            end
            if (rsp_drop) begin
                stat_dropped <= sat_inc(stat_dropped);
            end
            if (dec_valid && !dec_ready) begin
                stat_stall <= sat_inc(stat_stall);
            end
        end
    end
`endif

endmodule
